// File: rtl/axis_ascon_aead128_deframer.sv
// Splits a serialized AEAD frame (cmd, header, AD, ciphertext, tag) arriving on one
// 128-bit AXI-Stream into the cmd/ad/data/tag streams of an Ascon-AEAD128 decrypt core.
module axis_ascon_aead128_deframer #(
  parameter bit          force_decrypt = 1'b1,
  parameter int unsigned len_w         = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic         s_tlast,
  input  logic [127:0] s_tdata,
  output logic         m_cmd_tvalid,
  input  logic         m_cmd_tready,
  output logic [511:0] m_cmd_tdata,
  output logic         m_ad_tvalid,
  input  logic         m_ad_tready,
  output logic         m_ad_tlast,
  output logic [127:0] m_ad_tdata,
  output logic [15:0]  m_ad_tkeep,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         m_tlast,
  output logic [127:0] m_tdata,
  output logic [15:0]  m_tkeep,
  output logic         m_tag_tvalid,
  input  logic         m_tag_tready,
  output logic [127:0] m_tag_tdata,
  output logic         frame_err,
  output logic         frame_done
);

  localparam int unsigned cnt_w = len_w + 1;
  localparam logic [cnt_w-1:0] beat_bytes = cnt_w'(16);

  localparam logic [2:0] st_cmd   = 3'd0;
  localparam logic [2:0] st_hdr   = 3'd1;
  localparam logic [2:0] st_ad    = 3'd2;
  localparam logic [2:0] st_msg   = 3'd3;
  localparam logic [2:0] st_tag   = 3'd4;
  localparam logic [2:0] st_drain = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [1:0]       beat_idx;
  logic [383:0]     cmd_buf;
  logic [511:0]     cmd_full;
  logic [cnt_w-1:0] ad_rem, msg_rem;
  logic [cnt_w-1:0] hdr_ad, hdr_msg;
  logic             rdy, s_fire, err_c, done_c;

  assign hdr_ad  = {1'b0, s_tdata[len_w-1:0]};
  assign hdr_msg = {1'b0, s_tdata[2*len_w-1:len_w]};

  assign m_ad_tdata  = s_tdata;
  assign m_tdata     = s_tdata;
  assign m_tag_tdata = s_tdata;

  // Byte-length counters drive tlast and LSB-aligned tkeep directly.
  assign m_ad_tlast = (ad_rem <= beat_bytes);
  assign m_tlast    = (msg_rem <= beat_bytes);
  assign m_ad_tkeep = (ad_rem >= beat_bytes) ? 16'hFFFF : ~(16'hFFFF << ad_rem[3:0]);
  assign m_tkeep    = (msg_rem >= beat_bytes) ? 16'hFFFF : ~(16'hFFFF << msg_rem[3:0]);

  always_comb begin
    cmd_full = {s_tdata, cmd_buf};
    if (force_decrypt) cmd_full[256] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= st_cmd;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rdy          = 1'b0;
    m_ad_tvalid  = 1'b0;
    m_tvalid     = 1'b0;
    m_tag_tvalid = 1'b0;
    err_c        = 1'b0;
    done_c       = 1'b0;
    case (state)
      st_cmd: begin
        // Last cmd beat waits until the previous command has been taken.
        rdy = !(beat_idx == 2'd3 && m_cmd_tvalid && !s_tlast);
        if (s_tvalid && rdy) begin
          if (s_tlast) begin
            err_c = 1'b1;
          end else if (beat_idx == 2'd3) begin
            state_nxt = st_hdr;
          end
        end
      end
      st_hdr: begin
        rdy = 1'b1;
        if (s_tvalid) begin
          if (s_tlast) begin
            err_c     = 1'b1;
            state_nxt = st_cmd;
          end else if (hdr_ad != '0) begin
            state_nxt = st_ad;
          end else if (hdr_msg != '0) begin
            state_nxt = st_msg;
          end else begin
            state_nxt = st_tag;
          end
        end
      end
      st_ad: begin
        m_ad_tvalid = s_tvalid && !s_tlast;
        rdy         = s_tlast || m_ad_tready;
        if (s_tvalid && rdy) begin
          if (s_tlast) begin
            err_c     = 1'b1;
            state_nxt = st_cmd;
          end else if (m_ad_tlast) begin
            state_nxt = (msg_rem != '0) ? st_msg : st_tag;
          end
        end
      end
      st_msg: begin
        m_tvalid = s_tvalid && !s_tlast;
        rdy      = s_tlast || m_tready;
        if (s_tvalid && rdy) begin
          if (s_tlast) begin
            err_c     = 1'b1;
            state_nxt = st_cmd;
          end else if (m_tlast) begin
            state_nxt = st_tag;
          end
        end
      end
      st_tag: begin
        m_tag_tvalid = s_tvalid;
        rdy          = m_tag_tready;
        if (s_tvalid && rdy) begin
          if (s_tlast) begin
            done_c    = 1'b1;
            state_nxt = st_cmd;
          end else begin
            err_c     = 1'b1;
            state_nxt = st_drain;
          end
        end
      end
      st_drain: begin
        rdy = 1'b1;
        if (s_tvalid && s_tlast) state_nxt = st_cmd;
      end
      default: state_nxt = st_cmd;
    endcase
    s_tready = resetn && rdy;
    s_fire   = s_tvalid && rdy;
  end

  // Command assembly, header capture and remaining-byte bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_idx     <= 2'd0;
      cmd_buf      <= '0;
      m_cmd_tdata  <= '0;
      m_cmd_tvalid <= 1'b0;
      ad_rem       <= '0;
      msg_rem      <= '0;
      frame_err    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_err  <= err_c;
      frame_done <= done_c;
      if (m_cmd_tvalid && m_cmd_tready) m_cmd_tvalid <= 1'b0;
      if (state == st_cmd && s_fire) begin
        if (s_tlast) begin
          beat_idx <= 2'd0;
        end else begin
          beat_idx <= beat_idx + 2'd1;
          case (beat_idx)
            2'd0:    cmd_buf[127:0]   <= s_tdata;
            2'd1:    cmd_buf[255:128] <= s_tdata;
            2'd2:    cmd_buf[383:256] <= s_tdata;
            default: begin
              m_cmd_tdata  <= cmd_full;
              m_cmd_tvalid <= 1'b1;
            end
          endcase
        end
      end
      if (state == st_hdr && s_fire && !s_tlast) begin
        ad_rem  <= hdr_ad;
        msg_rem <= hdr_msg;
      end
      if (state == st_ad && s_fire && !s_tlast)
        ad_rem <= (ad_rem > beat_bytes) ? ad_rem - beat_bytes : '0;
      if (state == st_msg && s_fire && !s_tlast)
        msg_rem <= (msg_rem > beat_bytes) ? msg_rem - beat_bytes : '0;
    end
  end

endmodule
